// File: rtl/mem_pkg.sv
// Shared types and widths for the multicycle memory responder.
// Byte-lane count sizes the write strobes used under MEM_BYTE_EN.
package mem_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int BYTE_LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    ERR
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word array: per-lane write enables, registered read port.
// Only the read register is reset; stored words survive reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  re,
  input  logic [BYTE_LANES-1:0] we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (we[i]) begin
        mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory end of the MEM_RD/MEM_WD handshake with programmable wait states.
// Define MEM_BYTE_EN to add the be[3:0] per-byte write strobe port.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_rd,
  input  logic                  mem_wd,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
`ifdef MEM_BYTE_EN
  input  logic [BYTE_LANES-1:0] be,
`endif
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_ready,
  output logic                  mem_err
);

  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic                  req;
  logic                  bad;
  logic [BYTE_LANES-1:0] be_in;
  logic [IDX_W-1:0]      idx_in;

  logic                  acc;
  logic                  acc_wr;
  logic [IDX_W-1:0]      acc_idx;
  logic [DATA_W-1:0]     acc_wdata;
  logic [BYTE_LANES-1:0] acc_be;
  logic                  arr_re;
  logic [BYTE_LANES-1:0] arr_we;

`ifdef MEM_BYTE_EN
  assign be_in = be;
`else
  assign be_in = '1;
`endif

  assign req    = mem_rd | mem_wd;
  assign idx_in = addr[IDX_W+1:2];

  always_comb begin
    bad = (mem_rd & mem_wd)
        | (addr[1:0] != 2'b00)
        | ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));
`ifdef MEM_BYTE_EN
    bad = bad | (mem_wd & (be_in == '0));
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    acc       = 1'b0;
    acc_wr    = wr_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = mem_wd;
          idx_d   = idx_in;
          wdata_d = wdata;
          be_d    = be_in;
          if (bad) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            // No latched copy exists yet: access straight off the inputs
            state_d   = RESP;
            ready_d   = 1'b1;
            acc       = 1'b1;
            acc_wr    = mem_wd;
            acc_idx   = idx_in;
            acc_wdata = wdata;
            acc_be    = be_in;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          ready_d = 1'b1;
          acc     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign arr_re = acc & ~acc_wr & ~reset;
  assign arr_we = (acc & acc_wr & ~reset) ? acc_be : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .re   (arr_re),
    .we   (arr_we),
    .idx  (acc_idx),
    .wdata(acc_wdata),
    .rdata(rdata)
  );

  assign mem_ready = ready_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Random and directed requests against two responders (2 and 0 wait states)
// checked by a word-array model; build with MEM_BYTE_EN for byte strobes.
module tb_mem_responder;

  localparam int DEPTH = 256;
`ifdef MEM_BYTE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_i    [2];
  logic        wd_i    [2];
  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];
`ifdef MEM_BYTE_EN
  logic [3:0]  be_i    [2];
`endif
  logic [31:0] rdata_o [2];
  logic        rdy_o   [2];
  logic        err_o   [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mdl     [2][DEPTH];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(2)
  ) u_dut_w2 (
    .clk      (clk),
    .reset    (reset),
    .mem_rd   (rd_i[0]),
    .mem_wd   (wd_i[0]),
    .addr     (addr_i[0]),
    .wdata    (wdata_i[0]),
`ifdef MEM_BYTE_EN
    .be       (be_i[0]),
`endif
    .rdata    (rdata_o[0]),
    .mem_ready(rdy_o[0]),
    .mem_err  (err_o[0])
  );

  mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(0)
  ) u_dut_w0 (
    .clk      (clk),
    .reset    (reset),
    .mem_rd   (rd_i[1]),
    .mem_wd   (wd_i[1]),
    .addr     (addr_i[1]),
    .wdata    (wdata_i[1]),
`ifdef MEM_BYTE_EN
    .be       (be_i[1]),
`endif
    .rdata    (rdata_o[1]),
    .mem_ready(rdy_o[1]),
    .mem_err  (err_o[1])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  m);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // One full handshake on responder s; expectations come from the model.
  task automatic do_req(input int s, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  bm;
    int          wc;
    int          k;
    bit          done;
    wc      = (s == 0) ? 2 : 0;
    bm      = BE_EN ? b : 4'hF;
    exp_err = (r && w) || (a[1:0] != 2'b00) ||
              ((a >> 2) >= 32'(DEPTH)) || (w && bm == 4'h0);
    exp_rd  = last_rd[s];
    if (!exp_err && r) exp_rd = mdl[s][a[9:2]];
    @(negedge clk);
    rd_i[s]    = r;
    wd_i[s]    = w;
    addr_i[s]  = a;
    wdata_i[s] = d;
`ifdef MEM_BYTE_EN
    be_i[s]    = b;
`endif
    k    = 0;
    done = 1'b0;
    while (!done && k < 8) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        addr_i[s]  = $urandom;
        wdata_i[s] = $urandom;
      end
      if (rdy_o[s] || err_o[s]) done = 1'b1;
      else k++;
    end
    check("latency", done ? 32'(k) : 32'hFFFF_FFFF,
          exp_err ? 32'd0 : 32'(wc));
    check("ready", 32'(rdy_o[s]), 32'(!exp_err));
    check("err", 32'(err_o[s]), 32'(exp_err));
    check("rdata", rdata_o[s], exp_rd);
    rd_i[s] = 1'b0;
    wd_i[s] = 1'b0;
    @(posedge clk);
    #1;
    check("pulse", {30'd0, rdy_o[s], err_o[s]}, 32'd0);
    if (!exp_err && w) mdl[s][a[9:2]] = merge(mdl[s][a[9:2]], d, bm);
    last_rd[s] = exp_rd;
  endtask

  initial begin
    int          kind;
    int          s;
    logic [31:0] a;
    logic        r;
    logic        w;
    logic [3:0]  b;

    for (int i = 0; i < 2; i++) begin
      rd_i[i]    = 1'b0;
      wd_i[i]    = 1'b0;
      addr_i[i]  = '0;
      wdata_i[i] = '0;
`ifdef MEM_BYTE_EN
      be_i[i]    = 4'hF;
`endif
      last_rd[i] = '0;
    end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_rdata", rdata_o[i], 32'd0);
      check("rst_ready", 32'(rdy_o[i]), 32'd0);
      check("rst_err", 32'(err_o[i]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < 2; j++) begin
        do_req(j, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);
      end
    end

    do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    check("deadbeef", rdata_o[0], 32'hDEAD_BEEF);
    do_req(0, 1'b0, 1'b1, 32'h13, 32'h5555_5555, 4'hF);
    do_req(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    do_req(0, 1'b1, 1'b1, 32'h10, 32'h6666_6666, 4'hF);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    check("deadbeef_kept", rdata_o[0], 32'hDEAD_BEEF);

    do_req(1, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 4'hF);
    do_req(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    check("w0_read", rdata_o[1], 32'h1234_5678);
    do_req(1, 1'b1, 1'b0, 32'h2, 32'h0, 4'hF);

    @(negedge clk);
    wd_i[0]    = 1'b1;
    addr_i[0]  = 32'h20;
    wdata_i[0] = 32'hCAFE_F00D;
`ifdef MEM_BYTE_EN
    be_i[0]    = 4'hF;
`endif
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    wd_i[0] = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", 32'(rdy_o[0]), 32'd0);
    check("midrst_err", 32'(err_o[0]), 32'd0);
    check("midrst_rdata", rdata_o[0], 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    reset = 1'b0;
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);

`ifdef MEM_BYTE_EN
    do_req(0, 1'b0, 1'b1, 32'h30, 32'h1111_1111, 4'hF);
    do_req(0, 1'b0, 1'b1, 32'h30, 32'hAABB_CCDD, 4'b0101);
    do_req(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    check("be_merge", rdata_o[0], 32'h11BB_11DD);
    do_req(0, 1'b0, 1'b1, 32'h30, 32'h9999_9999, 4'b0000);
    do_req(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    check("be_zero_kept", rdata_o[0], 32'h11BB_11DD);
`endif

    for (int i = 0; i < 200; i++) begin
      s    = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, DEPTH - 1)) << 2;
      r    = 1'b0;
      w    = 1'b0;
      b    = 4'($urandom_range(0, 15));
      if (kind <= 3) begin
        r = 1'b1;
      end else if (kind <= 6) begin
        w = 1'b1;
      end else if (kind == 7) begin
        a = a | 32'($urandom_range(1, 3));
        r = $urandom_range(0, 1) == 1;
        w = !r;
      end else if (kind == 8) begin
        a = 32'(DEPTH * 4) + (32'($urandom_range(0, 4000)) << 2);
        r = $urandom_range(0, 1) == 1;
        w = !r;
      end else begin
        r = 1'b1;
        w = 1'b1;
      end
      do_req(s, r, w, a, $urandom, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
